// File: rtl/ikaopll_pg_multislot.sv
// Time-multiplexed FM phase generator: per-slot PM, block shift and MUL feed a
// slot-addressed phase store; the top OUT_W phase bits leave tagged with their slot.
module ikaopll_pg_multislot #(
  parameter int SLOTS   = 18,
  parameter int FNUM_W  = 9,
  parameter int BLOCK_W = 3,
  parameter int PHASE_W = 19,
  parameter int OUT_W   = 10
) (
  input  logic               i_EMUCLK,
  input  logic               i_RST,
  input  logic               i_CEN_n,
  input  logic               i_SLOT_SYNC,
  input  logic [FNUM_W-1:0]  i_FNUM,
  input  logic [BLOCK_W-1:0] i_BLOCK,
  input  logic [3:0]         i_MUL,
  input  logic               i_PM,
  input  logic [2:0]         i_PMVAL,
  input  logic               i_PHASE_RST,
  input  logic               i_FREEZE,
  output logic [4:0]         o_SLOT,
  output logic [OUT_W-1:0]   o_PHASE,
  output logic               o_VALID
);
  localparam int D_W = FNUM_W + 1;
  localparam int S_W = D_W + (1 << BLOCK_W) - 1;
  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

  logic [4:0]         slot_q, slot_d;
  logic [FNUM_W-1:0]  pm_mag_s;
  logic [D_W-1:0]     pm_base_s, pm_ext_s, d_s;
  logic [S_W-1:0]     shl_s, s1_val_d;
  logic [S_W-1:0]     s1_val_q;
  logic [3:0]         s1_mul_q;
  logic [4:0]         s1_slot_q;
  logic               s1_prst_q, s1_frz_q, v1_q;
  logic [S_W-1:0]     mul_base_s;
  logic [3:0]         mul_fac_s;
  logic [PHASE_W-1:0] delta_d, prev_d;
  logic [PHASE_W-1:0] s2_delta_q, s2_prev_q;
  logic [4:0]         s2_slot_q;
  logic               v2_q;
  logic [PHASE_W-1:0] new_s;
  logic [PHASE_W-1:0] store_q [SLOTS];

  // Input slot counter: sync load beats increment and wrap.
  always_comb begin
    slot_d = slot_q;
    if (i_SLOT_SYNC) begin
      slot_d = 5'd0;
    end else if (slot_q == LAST_SLOT) begin
      slot_d = 5'd0;
    end else begin
      slot_d = slot_q + 5'd1;
    end
  end

  // Stage 1 datapath: PM offset on the doubled F-number, then octave shift.
  always_comb begin
    pm_mag_s = '0;
    if (i_PM && (i_PMVAL[1:0] != 2'd0)) begin
      if (i_PMVAL[1:0] == 2'd2) begin
        pm_mag_s = i_FNUM >> (FNUM_W - 3);
      end else begin
        pm_mag_s = i_FNUM >> (FNUM_W - 2);
      end
    end else begin
      pm_mag_s = '0;
    end
    pm_base_s = {i_FNUM, 1'b0};
    pm_ext_s  = {1'b0, pm_mag_s};
    if (i_PMVAL[2]) begin
      if (pm_base_s < pm_ext_s) begin
        d_s = '0;
      end else begin
        d_s = pm_base_s - pm_ext_s;
      end
    end else begin
      d_s = pm_base_s + pm_ext_s;
    end
    shl_s    = {{(S_W - D_W){1'b0}}, d_s} << i_BLOCK;
    s1_val_d = shl_s >> 1;
  end

  // Stage 2 datapath: MUL factor lookup and phase store read for the slot.
  always_comb begin
    mul_base_s = s1_val_q;
    mul_fac_s  = s1_mul_q;
    case (s1_mul_q)
      4'd0: begin
        mul_base_s = s1_val_q >> 1;
        mul_fac_s  = 4'd1;
      end
      4'd10, 4'd11: mul_fac_s = 4'd10;
      4'd12, 4'd13: mul_fac_s = 4'd12;
      4'd14, 4'd15: mul_fac_s = 4'd15;
      default:      mul_fac_s = s1_mul_q;
    endcase
    // Truncating the operands first gives the same low PHASE_W product bits.
    if (s1_frz_q) begin
      delta_d = '0;
    end else begin
      delta_d = PHASE_W'(mul_base_s) * PHASE_W'(mul_fac_s);
    end
    if (s1_prst_q) begin
      prev_d = '0;
    end else begin
      prev_d = store_q[s1_slot_q];
    end
  end

  // Stage 3 datapath: modular accumulate.
  always_comb begin
    new_s = s2_prev_q + s2_delta_q;
  end

  // Pipeline, slot counter, phase store and output registers.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      slot_q     <= 5'd0;
      s1_val_q   <= '0;
      s1_mul_q   <= 4'd0;
      s1_slot_q  <= 5'd0;
      s1_prst_q  <= 1'b0;
      s1_frz_q   <= 1'b0;
      v1_q       <= 1'b0;
      s2_delta_q <= '0;
      s2_prev_q  <= '0;
      s2_slot_q  <= 5'd0;
      v2_q       <= 1'b0;
      o_SLOT     <= 5'd0;
      o_PHASE    <= '0;
      o_VALID    <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        store_q[i] <= '0;
      end
    end else if (!i_CEN_n) begin
      slot_q     <= slot_d;
      s1_val_q   <= s1_val_d;
      s1_mul_q   <= i_MUL;
      s1_slot_q  <= slot_q;
      s1_prst_q  <= i_PHASE_RST;
      s1_frz_q   <= i_FREEZE;
      v1_q       <= 1'b1;
      s2_delta_q <= delta_d;
      s2_prev_q  <= prev_d;
      s2_slot_q  <= s1_slot_q;
      v2_q       <= v1_q;
      store_q[s2_slot_q] <= new_s;
      o_SLOT     <= s2_slot_q;
      o_PHASE    <= new_s[PHASE_W-1 -: OUT_W];
      o_VALID    <= v2_q;
    end
  end
endmodule

// File: tb/tb_ikaopll_pg_multislot.sv
// Bench for ikaopll_pg_multislot: directed frames plus randomized traffic checked
// against an arithmetic per-slot phase model with a 3-deep expectation queue.
module tb_ikaopll_pg_multislot;
  localparam int SLOTS   = 18;
  localparam int FNUM_W  = 9;
  localparam int BLOCK_W = 3;
  localparam int PHASE_W = 19;
  localparam int OUT_W   = 10;
  localparam int PMOD    = 1 << PHASE_W;
  localparam int OSH     = PHASE_W - OUT_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cen_n = 1'b0;
  logic               sync = 1'b0;
  logic [FNUM_W-1:0]  fnum = '0;
  logic [BLOCK_W-1:0] block = '0;
  logic [3:0]         mul = 4'd0;
  logic               pm = 1'b0;
  logic [2:0]         pmval = 3'd0;
  logic               prst = 1'b0;
  logic               frz = 1'b0;
  logic [4:0]         o_slot;
  logic [OUT_W-1:0]   o_phase;
  logic               o_valid;

  always #5 clk = ~clk;

  ikaopll_pg_multislot #(
    .SLOTS(SLOTS), .FNUM_W(FNUM_W), .BLOCK_W(BLOCK_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)
  ) dut (
    .i_EMUCLK(clk), .i_RST(rst), .i_CEN_n(cen_n), .i_SLOT_SYNC(sync),
    .i_FNUM(fnum), .i_BLOCK(block), .i_MUL(mul), .i_PM(pm), .i_PMVAL(pmval),
    .i_PHASE_RST(prst), .i_FREEZE(frz),
    .o_SLOT(o_slot), .o_PHASE(o_phase), .o_VALID(o_valid)
  );

  typedef struct { int slot; int phase; } exp_t;

  int         errors = 0;
  int         checks = 0;
  int         fn_a [SLOTS];
  int         bl_a [SLOTS];
  int         mu_a [SLOTS];
  bit         pm_a [SLOTS];
  logic [2:0] pmv = 3'd0;
  int         ph [SLOTS];
  int         cnt = 0;
  exp_t       expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Phase increment straight from the frequency rules, in plain integers.
  function automatic int calc_delta(input int f, input int b, input int mu, input bit p,
                                    input logic [2:0] pv);
    int     fac [16] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 12, 12, 15, 15};
    int     m;
    int     d;
    longint s;
    longint r;
    m = 0;
    if (p && pv[1:0] != 2'd0) m = (pv[1:0] == 2'd2) ? (f >> (FNUM_W - 3)) : (f >> (FNUM_W - 2));
    d = pv[2] ? (2 * f - m) : (2 * f + m);
    if (d < 0) d = 0;
    d = d % (1 << (FNUM_W + 1));
    s = (longint'(d) * (longint'(1) << b)) / 2;
    r = (mu == 0) ? (s / 2) : (s * fac[mu]);
    return int'(r % PMOD);
  endfunction

  task automatic check_outputs();
    if (expq.size() == 3) begin
      chk("slot", o_slot, expq[0].slot);
      chk("phase", o_phase, expq[0].phase >> OSH);
      chk("valid", o_valid, 1);
    end else begin
      chk("fill_slot", o_slot, 0);
      chk("fill_phase", o_phase, 0);
      chk("fill_valid", o_valid, 0);
    end
  endtask

  // One clock: drive the current model slot's settings, update the model, compare.
  task automatic tick(input bit c_n, input bit s, input bit pr, input bit fz, input bit r);
    int dl;
    int prev;
    cen_n = c_n; sync = s; prst = pr; frz = fz; rst = r;
    fnum  = FNUM_W'(fn_a[cnt]);
    block = BLOCK_W'(bl_a[cnt]);
    mul   = 4'(mu_a[cnt]);
    pm    = pm_a[cnt];
    pmval = pmv;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < SLOTS; i++) ph[i] = 0;
      cnt = 0;
      expq.delete();
    end else if (!c_n) begin
      dl = fz ? 0 : calc_delta(fn_a[cnt], bl_a[cnt], mu_a[cnt], pm_a[cnt], pmv);
      prev = pr ? 0 : ph[cnt];
      ph[cnt] = (prev + dl) % PMOD;
      expq.push_back('{slot: cnt, phase: ph[cnt]});
      if (expq.size() > 3) void'(expq.pop_front());
      cnt = s ? 0 : ((cnt == SLOTS - 1) ? 0 : cnt + 1);
    end
    check_outputs();
  endtask

  task automatic wait_slot(input int s, input string tag);
    int n;
    n = 0;
    do begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!(o_valid === 1'b1 && o_slot === 5'(s)) && n < 4 * SLOTS);
    if (!(o_valid === 1'b1 && o_slot === 5'(s))) chk({tag, "_timeout"}, o_slot, s);
  endtask

  task automatic run_to(input int s);
    for (int i = 0; i < SLOTS && cnt != s; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < SLOTS; i++) begin
      fn_a[i] = 0; bl_a[i] = 0; mu_a[i] = 0; pm_a[i] = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rf [8] = '{256, 256, 256, 256, 256, 256, 256, 511};
    int rb [8] = '{4, 4, 4, 4, 4, 4, 4, 7};
    int rm [8] = '{1, 0, 11, 15, 1, 1, 1, 15};
    int rp [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    int rv [8] = '{0, 0, 0, 0, 2, 6, 1, 0};
    int rd [8] = '{4096, 2048, 40960, 61440, 4128, 4064, 4096, 456832};
    int d5;

    // Directed single-slot frames: absolute phase after visits 1, 2 and 16.
    for (int r = 0; r < 8; r++) begin
      clear_tables();
      fn_a[0] = rf[r]; bl_a[0] = rb[r]; mu_a[0] = rm[r]; pm_a[0] = rp[r][0];
      pmv = 3'(rv[r]);
      do_reset();
      chk("reset_valid", o_valid, 0);
      for (int v = 1; v <= 16; v++) begin
        wait_slot(0, "visit");
        if (v == 1 || v == 2 || v == 16)
          chk($sformatf("row%0d_v%0d", r, v), o_phase, ((v * rd[r]) % PMOD) >> OSH);
      end
      if (r == 0) begin
        wait_slot(1, "other");
        chk("other_slot_zero", o_phase, 0);
      end
    end

    // Randomized traffic with stalls, PM, key-on and freeze pulses.
    for (int i = 0; i < SLOTS; i++) begin
      fn_a[i] = $urandom_range(0, 500); bl_a[i] = $urandom_range(0, 7);
      mu_a[i] = $urandom_range(0, 15);  pm_a[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 600; i++) begin
      pmv = 3'($urandom_range(0, 7));
      if (i % 97 == 0) begin
        fn_a[i % SLOTS] = $urandom_range(0, 500);
        mu_a[i % SLOTS] = $urandom_range(0, 15);
      end
      tick(1'($urandom_range(0, 3) == 0), 1'b0, 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 19) == 0), 1'b0);
    end

    // Key-on on slot 5, then a two-frame freeze, then key-on with freeze.
    pmv = 3'd0;
    fn_a[5] = 300; bl_a[5] = 6; mu_a[5] = 3; pm_a[5] = 1'b0;
    d5 = calc_delta(300, 6, 3, 1'b0, 3'd0);
    run_to(5);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_slot(5, "prst");
    chk("prst_slot5", o_phase, d5 >> OSH);
    for (int i = 0; i < 2 * SLOTS; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i >= 3 && o_slot === 5'd5) chk("freeze_slot5", o_phase, d5 >> OSH);
    end
    run_to(5);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_slot(5, "prst_frz");
    chk("prst_frz_zero", o_phase, 0);

    // Resync at counter 7, then a mid-frame reset and requalification.
    run_to(7);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k >= 3) chk("sync_seq", o_slot, k - 3);
    end
    fn_a[0] = 256; bl_a[0] = 4; mu_a[0] = 15; pm_a[0] = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_phase", o_phase, 0);
    chk("midrst_valid", o_valid, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("requal_early", o_valid, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("requal_valid", o_valid, 1);
    chk("restart_slot", o_slot, 0);
    chk("restart_phase", o_phase, 61440 >> OSH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ikaopll_pg_multislot.md
Name: ikaopll_pg_multislot

Overview:
Parametrised, time-multiplexed phase generator for the FM operator path. It serves SLOTS operator slots, one per enabled clock. Per slot it applies PM, octave (block) shift and MUL, then accumulates into a per-slot phase store that is addressed by slot index rather than held in a delay chain. It emits the top OUT_W bits of each slot's phase, tagged with the slot index, to the operator block.

Parameters:
SLOTS, 18, number of operator slots; legal range 4..32.
FNUM_W, 9, F-number width; minimum 3.
BLOCK_W, 3, block (octave) width.
PHASE_W, 19, accumulator width per slot.
OUT_W, 10, output phase width; must be <= PHASE_W.

Ports:
i_EMUCLK  in  1  master clock
i_RST  in  1  synchronous reset, active-high
i_CEN_n  in  1  clock enable, active-low; all state advances only when low
i_SLOT_SYNC  in  1  forces the input slot counter to 0 on this enabled cycle
i_FNUM  in  FNUM_W  F-number for the current input slot
i_BLOCK  in  BLOCK_W  octave for the current input slot
i_MUL  in  4  multiplier code for the current input slot
i_PM  in  1  PM enable for the current input slot
i_PMVAL  in  3  global PM value; bit 2 = sign, bits 1:0 = depth
i_PHASE_RST  in  1  current input slot restarts its phase (key-on)
i_FREEZE  in  1  test: delta forced to 0; phase holds
o_SLOT  out  5  slot index of o_PHASE
o_PHASE  out  OUT_W  phase[PHASE_W-1 -: OUT_W]
o_VALID  out  1  high once the pipeline is filled

Behaviour:
- Reset (i_RST high on any clock edge, regardless of i_CEN_n):
  - slot counter = 0; all pipeline registers = 0; every phase store entry = 0.
  - o_PHASE = 0, o_SLOT = 0, o_VALID = 0.
- Slot counter: increments once per enabled cycle and wraps from SLOTS-1 to 0.
  - i_SLOT_SYNC on an enabled cycle loads 0; it takes precedence over increment and wrap.
  - Resync mid-frame is legal. Slots that were skipped keep their phase; nothing is corrupted.
- Pipeline: inputs are sampled together with the counter value (stage 0), and the slot index travels with the data.
  - S1: PM offset and block shift.
  - S2: MUL, plus phase store read for that slot.
  - S3: add and write back; o_PHASE and o_SLOT are registered here.
  - Latency is 3 enabled cycles from input to output.
- PM offset: enabled only when i_PM = 1 and i_PMVAL[1:0] != 0; otherwise the offset is 0.
  - Magnitude m: fnum >> (FNUM_W-2) for depth 1 or 3; fnum >> (FNUM_W-3) for depth 2.
  - d = {fnum,1'b0} + m, or - m if i_PMVAL[2] = 1. Computed in FNUM_W+1 bits, with a negative result clamped to 0.
- Block shift: s = (d << block) >> 1, computed at full width.
- MUL table, code -> factor:
  - 0 -> ×½ (s >> 1); 1-9 -> same value; 10, 11 -> 10; 12, 13 -> 12; 14, 15 -> 15.
  - The product is truncated to PHASE_W bits.
- Accumulate: new = prev + delta, modulo 2^PHASE_W (wraps silently).
  - i_PHASE_RST: prev is treated as 0, so new = delta.
  - i_FREEZE: delta is treated as 0.
  - Both asserted: new = 0.
- Hazard: a slot's write (S3) always precedes its next read. SLOTS >= 4 guarantees this; no bypass is required.
- o_VALID: rises on the 3rd enabled cycle after reset deassertion and then stays high until the next reset.
- Disabled cycles (i_CEN_n high): all state and outputs hold.
- Out-of-range slot indices are unreachable; o_SLOT is zero-extended to 5 bits.

Test Plan:
1. Reset, then slot 0 held at FNUM=256, BLOCK=4, MUL=1, PM=0, all other slots at FNUM=0 -> delta 4096; on slot 0's Nth output, phase = N·4096 and o_PHASE = N·8; o_VALID = 1 from enabled cycle 3; other slots read 0.
2. Same settings with MUL=0 -> delta 2048; MUL=11 -> delta 40960; MUL=15 -> delta 61440; per-visit o_PHASE steps are 4, 80 and 120 respectively.
3. FNUM=256, BLOCK=4, PM=1: PMVAL=2 -> delta 4128; PMVAL=6 -> delta 4064; PMVAL=1 with PM=0 -> delta 4096.
4. FNUM=511, BLOCK=7, MUL=15 -> delta 981120 mod 2^19 = 456832; after the second visit phase = 913664 mod 524288 = 389376 (wrap check).
5. Mid-run: pulse i_PHASE_RST on slot 5 -> slot 5 phase equals exactly one delta; i_FREEZE for 2 frames -> all phases unchanged; both asserted -> slot phase = 0.
6. Pulse i_SLOT_SYNC at counter = 7 -> next o_SLOT sequence after 3 cycles is 0,1,2…; assert i_RST mid-frame -> outputs 0 on the next edge, all phases restart from 0, and o_VALID re-qualifies after 3 enabled cycles.
